// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm FSM (IDLE/ARMED/RINGING/SNOOZE) for a 12-hour BCD clock.
// Define ALARM_SNOOZE_EN to build the SNOOZE state and its counter.
module alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 540
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       set_pm,
  input  logic       alarm_en,
  input  logic       stop,
  input  logic       snooze,
  output logic       ring,
  output logic       snoozing,
  output logic       set_err
);

  localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] RING_LOAD = CW'(RING_SECS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
`ifdef ALARM_SNOOZE_EN
    RINGING = 2'd2,
    SNOOZE  = 2'd3
`else
    RINGING = 2'd2
`endif
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] ring_cnt_reg, ring_cnt_next;
  logic [7:0]    alm_hh_reg, alm_mm_reg;
  logic          alm_pm_reg;
  logic          match_reg;
  logic          ring_reg;
  logic          set_err_reg;

  logic match_now, trigger, set_fire, set_good;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // BCD digits order the same as binary, so range checks compare raw bytes.
  assign set_ready = (state_reg != RINGING);
  assign set_fire  = set_valid && set_ready;
  assign set_good  = bcd_ok(set_hh) && bcd_ok(set_mm) &&
                     (set_hh >= 8'h01) && (set_hh <= 8'h12) && (set_mm <= 8'h59);
  assign match_now = (hh == alm_hh_reg) && (mm == alm_mm_reg) &&
                     (pm == alm_pm_reg) && (ss == 8'h00);
  assign trigger   = match_now && !match_reg;

  assign ring    = ring_reg;
  assign set_err = set_err_reg;

`ifdef ALARM_SNOOZE_EN
  localparam logic [CW-1:0] SNZ_LOAD = CW'(SNOOZE_SECS);
  logic [CW-1:0] snz_cnt_reg, snz_cnt_next;
  logic          snoozing_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snz_cnt_reg  <= '0;
      snoozing_reg <= 1'b0;
    end else begin
      snz_cnt_reg  <= snz_cnt_next;
      snoozing_reg <= (state_next == SNOOZE);
    end
  end

  assign snoozing = snoozing_reg;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snoozing      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      ring_cnt_reg <= '0;
      alm_hh_reg   <= 8'h12;
      alm_mm_reg   <= 8'h00;
      alm_pm_reg   <= 1'b0;
      match_reg    <= 1'b0;
      ring_reg     <= 1'b0;
      set_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ring_cnt_reg <= ring_cnt_next;
      match_reg    <= match_now;
      ring_reg     <= (state_next == RINGING);
      set_err_reg  <= set_fire && !set_good;
      if (set_fire && set_good) begin
        alm_hh_reg <= set_hh;
        alm_mm_reg <= set_mm;
        alm_pm_reg <= set_pm;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ring_cnt_next = ring_cnt_reg;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_next  = snz_cnt_reg;
`endif
    if (!alarm_en) begin
      state_next    = IDLE;
      ring_cnt_next = '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_next  = '0;
`endif
    end else begin
      case (state_reg)
        IDLE: state_next = ARMED;
        ARMED: begin
          if (trigger) begin
            state_next    = RINGING;
            ring_cnt_next = RING_LOAD;
          end
        end
        RINGING: begin
          if (stop) begin
            state_next    = ARMED;
            ring_cnt_next = '0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze) begin
            state_next    = SNOOZE;
            ring_cnt_next = '0;
            snz_cnt_next  = SNZ_LOAD;
          end
`endif
          else if (ena) begin
            // The tick that empties the counter ends the ring; never wraps.
            if (ring_cnt_reg <= CNT_ONE) begin
              state_next    = ARMED;
              ring_cnt_next = '0;
            end else begin
              ring_cnt_next = ring_cnt_reg - CNT_ONE;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop) begin
            state_next   = ARMED;
            snz_cnt_next = '0;
          end else if (ena) begin
            if (snz_cnt_reg <= CNT_ONE) begin
              state_next    = RINGING;
              snz_cnt_next  = '0;
              ring_cnt_next = RING_LOAD;
            end else begin
              snz_cnt_next = snz_cnt_reg - CNT_ONE;
            end
          end
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed alarm scenarios plus random traffic, checked each
// cycle against a seconds-level behavioural model of the alarm.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] hh = 8'h12, mm = 8'h00, ss = 8'h00;
  logic       pm = 1'b0;
  logic       set_valid = 1'b0;
  logic       set_ready;
  logic [7:0] set_hh = 8'h00, set_mm = 8'h00;
  logic       set_pm = 1'b0;
  logic       alarm_en = 1'b0;
  logic       stop = 1'b0, snooze = 1'b0;
  logic       ring, snoozing, set_err;

  int n_tests = 0;
  int n_fail  = 0;
  int now_sec = 6 * 3600;

`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  localparam int RING_T = 60;
  localparam int SNZ_T  = 540;
  localparam int M_IDLE = 0, M_ARM = 1, M_RING = 2, M_SNZ = 3;

  always #5 clk = ~clk;

  alarm_ctrl dut (
    .clk(clk), .reset(reset), .ena(ena),
    .hh(hh), .mm(mm), .ss(ss), .pm(pm),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_hh(set_hh), .set_mm(set_mm), .set_pm(set_pm),
    .alarm_en(alarm_en), .stop(stop), .snooze(snooze),
    .ring(ring), .snoozing(snoozing), .set_err(set_err)
  );

  // ---------------- behavioural model ----------------
  int         mode = M_IDLE;
  int         left = 0;
  logic [7:0] a_hh = 8'h12, a_mm = 8'h00;
  logic       a_pm = 1'b0;
  bit         prev_m = 1'b0;
  bit         e_err = 1'b0;

  function automatic int bcd_num(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return -1;
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int hms(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic model_reset();
    mode = M_IDLE; left = 0; a_hh = 8'h12; a_mm = 8'h00; a_pm = 1'b0;
    prev_m = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step();
    bit m, trig;
    int h, mi;
    m = (hh == a_hh) && (mm == a_mm) && (pm == a_pm) && (ss == 8'h00);
    trig = m && !prev_m;
    prev_m = m;
    e_err = 1'b0;
    if (set_valid && mode != M_RING) begin
      h  = bcd_num(set_hh);
      mi = bcd_num(set_mm);
      if (h >= 1 && h <= 12 && mi >= 0 && mi <= 59) begin
        a_hh = set_hh; a_mm = set_mm; a_pm = set_pm;
      end else begin
        e_err = 1'b1;
      end
    end
    if (!alarm_en) mode = M_IDLE;
    else if (mode == M_IDLE) mode = M_ARM;
    else if (mode == M_ARM) begin
      if (trig) begin mode = M_RING; left = RING_T; end
    end else if (stop) mode = M_ARM;
    else if (mode == M_RING && snooze && SNZ) begin
      mode = M_SNZ; left = SNZ_T;
    end else if (ena) begin
      left = left - 1;
      if (left <= 0) begin
        if (mode == M_RING) mode = M_ARM;
        else begin mode = M_RING; left = RING_T; end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) model_reset();
    else model_step();
  end

  task automatic check(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    check("ring", ring, mode == M_RING);
    check("snoozing", snoozing, mode == M_SNZ);
    check("set_err", set_err, e_err);
    check("set_ready", set_ready, mode != M_RING);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_time();
    int h24, h12;
    h24 = now_sec / 3600;
    h12 = h24 % 12;
    if (h12 == 0) h12 = 12;
    hh = to_bcd(h12);
    mm = to_bcd((now_sec / 60) % 60);
    ss = to_bcd(now_sec % 60);
    pm = (h24 >= 12);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic tick();
    ena = 1'b1;
    cyc();
    ena = 1'b0;
    now_sec = (now_sec + 1) % 86400;
    drive_time();
    repeat ($urandom_range(0, 2)) cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic jump(input int s);
    now_sec = s;
    drive_time();
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic p);
    set_hh = h; set_mm = m; set_pm = p; set_valid = 1'b1;
    cyc();
    set_valid = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive_time();
    repeat (3) cyc();
    check("rst_ring", ring, 1'b0);
    check("rst_snoozing", snoozing, 1'b0);
    check("rst_set_err", set_err, 1'b0);
    check("rst_set_ready", set_ready, 1'b1);
    alarm_en = 1'b1;
    reset = 1'b1;
    cyc();

    load(8'h13, 8'h00, 1'b0);
    check("err_hh13", set_err, 1'b1);
    cyc();
    check("err_clears", set_err, 1'b0);
    load(8'h07, 8'h5A, 1'b0);
    check("err_nonbcd", set_err, 1'b1);
    load(8'h07, 8'h30, 1'b0);
    check("load_ok", set_err, 1'b0);

    // 07:30 AM ring lasts exactly 60 ticks
    jump(hms(7, 29, 58));
    ticks(2);
    cyc();
    check("ring_start", ring, 1'b1);
    ticks(RING_T - 1);
    check("ring_tick59", ring, 1'b1);
    tick();
    check("ring_expired", ring, 1'b0);

    // stop, blocked load during ring, no PM re-ring
    jump(hms(7, 29, 58));
    ticks(2);
    cyc();
    check("ring_again", ring, 1'b1);
    ticks(2);
    set_hh = 8'h08; set_mm = 8'h00; set_pm = 1'b0; set_valid = 1'b1;
    #1;
    check("ready_ringing", set_ready, 1'b0);
    cyc();
    set_valid = 1'b0;
    pulse_stop();
    check("stop_ring", ring, 1'b0);
    ticks(58);
    check("no_rering", ring, 1'b0);
    jump(hms(19, 29, 58));
    ticks(7);
    check("pm_skip", ring, 1'b0);

    // snooze at 07:30:05, re-ring at 07:39:05
    jump(hms(7, 29, 58));
    ticks(2);
    cyc();
    check("ring_kept_alarm", ring, 1'b1);
    ticks(5);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    check("snz_ring", ring, !SNZ);
    check("snz_flag", snoozing, SNZ);
    ticks(SNZ_T - 1);
    check("snz_wait_ring", ring, 1'b0);
    check("snz_wait_flag", snoozing, SNZ);
    tick();
    check("snz_rering", ring, SNZ);
    pulse_stop();
    check("snz_stop", ring, 1'b0);

    // alarm_en drop beats stop and snooze
    jump(hms(7, 29, 59));
    tick();
    cyc();
    check("en_ring", ring, 1'b1);
    alarm_en = 1'b0; stop = 1'b1; snooze = 1'b1;
    cyc();
    alarm_en = 1'b1; stop = 1'b0; snooze = 1'b0;
    check("en_drop_ring", ring, 1'b0);
    check("en_drop_snz", snoozing, 1'b0);

    // asynchronous reset while ringing, alarm returns to 12:00 AM
    jump(hms(7, 29, 59));
    tick();
    cyc();
    check("pre_reset_ring", ring, 1'b1);
    reset = 1'b0;
    #1;
    check("async_ring", ring, 1'b0);
    check("async_snz", snoozing, 1'b0);
    repeat (2) cyc();
    reset = 1'b1;
    jump(hms(23, 59, 58));
    ticks(2);
    cyc();
    check("midnight_ring", ring, 1'b1);
    pulse_stop();

    // random traffic around a 03:15 PM alarm
    for (int i = 0; i < 4000; i++) begin
      logic e;
      e = ($urandom_range(0, 1) == 1);
      ena = e;
      stop = ($urandom_range(0, 79) == 0);
      snooze = ($urandom_range(0, 49) == 0);
      alarm_en = ($urandom_range(0, 199) != 0);
      set_valid = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 3))
        0, 1: begin set_hh = 8'h03; set_mm = 8'h15; set_pm = 1'b1; end
        2: begin
          set_hh = 8'($urandom_range(0, 255));
          set_mm = 8'($urandom_range(0, 255));
          set_pm = 1'($urandom_range(0, 1));
        end
        default: begin
          set_hh = to_bcd($urandom_range(1, 12));
          set_mm = to_bcd($urandom_range(0, 59));
          set_pm = 1'($urandom_range(0, 1));
        end
      endcase
      cyc();
      if (e) now_sec = (now_sec + 1) % 86400;
      if ($urandom_range(0, 249) == 0) now_sec = hms(15, 14, 57);
      drive_time();
    end
    ena = 1'b0; stop = 1'b0; snooze = 1'b0; set_valid = 1'b0; alarm_en = 1'b1;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
